// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, redirect flush and EX operand
// forward selection, driven by a shadow scoreboard of the EX/MEM/WB stages.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_rd,
  input  logic        id_rf_we,
  input  logic [1:0]  id_wd_sel,
  input  logic        ex_redirect,
  output logic        stall_pc,
  output logic        stall_ifid,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic [1:0]  fwd_rs1_sel,
  output logic [1:0]  fwd_rs2_sel,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 32;

  localparam logic [1:0] WD_LOAD  = 2'b10;
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_EX   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             we;
    logic             is_load;
  } slot_t;

  slot_t ex_q, mem_q, wb_q;
  slot_t id_slot;

  logic       load_use_c;
  logic       redirect_c;
  logic       bubble_c;
  logic [1:0] fwd_rs1_c;
  logic [1:0] fwd_rs2_c;

  // x0 is hardwired, so a slot writing it is never a producer
  function automatic logic is_writer(input slot_t s);
    return s.valid && s.we && (s.rd != REG_W'(0));
  endfunction

  // Nearest producer wins; a load in EX has no data yet and cannot forward
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs,
                                         input slot_t ex, input slot_t mem);
    if (is_writer(ex) && !ex.is_load && (ex.rd == rs))
      return FWD_EX;
    else if (is_writer(mem) && (mem.rd == rs))
      return FWD_MEM;
    else
      return FWD_NONE;
  endfunction

  always_comb begin
    id_slot    = '{valid: id_valid, rd: id_rd, we: id_rf_we,
                   is_load: (id_wd_sel == WD_LOAD)};
    redirect_c = !rst && ex_redirect;
    load_use_c = !rst && id_valid && is_writer(ex_q) && ex_q.is_load &&
                 ((id_rs1_used && (id_rs1 == ex_q.rd)) ||
                  (id_rs2_used && (id_rs2 == ex_q.rd)));
    bubble_c   = redirect_c || load_use_c;
    fwd_rs1_c  = fwd_sel(id_rs1, ex_q, mem_q);
    fwd_rs2_c  = fwd_sel(id_rs2, ex_q, mem_q);
  end

  // Redirect overrides load-use: the stalled instruction is squashed anyway
  assign stall_pc   = load_use_c && !redirect_c;
  assign stall_ifid = load_use_c && !redirect_c;
  assign flush_ifid = redirect_c;
  assign flush_idex = bubble_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      fwd_rs1_sel <= FWD_NONE;
      fwd_rs2_sel <= FWD_NONE;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (bubble_c) begin
        ex_q        <= '0;
        fwd_rs1_sel <= FWD_NONE;
        fwd_rs2_sel <= FWD_NONE;
      end else begin
        ex_q        <= id_slot;
        fwd_rs1_sel <= fwd_rs1_c;
        fwd_rs2_sel <= fwd_rs2_c;
      end
      if (stall_pc)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect_c)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have the port `clk`, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `rst`, input, 1 bit: reset, synchronous, active-high.
REQ-003 The block SHALL have the port `id_valid`, input, 1 bit: the IF/ID register holds a real instruction.
REQ-004 The block SHALL have the ports `id_rs1` and `id_rs2`, input, 5 bits each: source register numbers of the instruction in ID.
REQ-005 The block SHALL have the ports `id_rs1_used` and `id_rs2_used`, input, 1 bit each: the ID instruction reads that source.
REQ-006 The block SHALL have the port `id_rd`, input, 5 bits: destination register of the ID instruction.
REQ-007 The block SHALL have the port `id_rf_we`, input, 1 bit: the ID instruction writes the register file.
REQ-008 The block SHALL have the port `id_wd_sel`, input, 2 bits: writeback source of the ID instruction; 2'b10 means load data.
REQ-009 The block SHALL have the port `ex_redirect`, input, 1 bit: a taken branch, jal or jalr resolved in EX this cycle.
REQ-010 The block SHALL have the port `stall_pc`, output, 1 bit: hold the PC.
REQ-011 The block SHALL have the port `stall_ifid`, output, 1 bit: hold the IF/ID register.
REQ-012 The block SHALL have the port `flush_ifid`, output, 1 bit: load a bubble into IF/ID.
REQ-013 The block SHALL have the port `flush_idex`, output, 1 bit: load a bubble into ID/EX.
REQ-014 The block SHALL have the ports `fwd_rs1_sel` and `fwd_rs2_sel`, output, 2 bits each, registered: EX operand source; 00 = ID/EX register value, 01 = EX/MEM ALU result, 10 = MEM/WB writeback value, 11 = reserved, never driven.
REQ-015 The block SHALL have the ports `stall_cnt` and `flush_cnt`, output, 32 bits each: event counters.

Function
REQ-016 The block SHALL keep a shadow scoreboard of three slots, EX, MEM and WB; each slot holds {valid, rd, we, is_load}, where is_load = (wd_sel == 2'b10).
REQ-017 On each clock edge, the WB slot SHALL take the MEM slot and the MEM slot SHALL take the EX slot.
REQ-018 On each clock edge, the EX slot SHALL take the ID fields (valid = id_valid), unless a bubble is inserted, in which case EX.valid = 0.
REQ-019 A slot SHALL count as a writer only when valid, we = 1 and rd != 0; x0 SHALL never cause a hazard or a forward.
REQ-020 Load-use stall: when the EX slot is a load writer, its rd matches a used ID source, and id_valid = 1, then stall_pc = stall_ifid = flush_idex = 1 for exactly one cycle and a bubble enters the EX slot.
REQ-021 After the load-use stall cycle the load SHALL be in MEM, so the same ID instruction SHALL no longer match the EX slot and SHALL proceed.
REQ-022 Redirect: when ex_redirect = 1, flush_ifid = flush_idex = 1, stall_pc = stall_ifid = 0, and a bubble enters the EX slot.
REQ-023 Redirect SHALL take priority over load-use; when both occur in the same cycle, only the redirect action SHALL occur.
REQ-024 Forward select, computed from ID versus the pre-edge slots and registered on the edge that moves ID into EX: if the EX slot is a non-load writer with matching rd, select 01; else if the MEM slot is a writer with matching rd, select 10; else select 00.
REQ-025 The forward select SHALL use that priority per source independently, with the nearer producer winning.
REQ-026 When ID does not advance (a bubble is inserted), both forward selects SHALL be registered as 00.
REQ-027 The register file is write-through, so a producer three or more ahead SHALL need no forward.
REQ-028 All stall and flush outputs SHALL be combinational from the slots and inputs, with zero-cycle latency.
REQ-029 `stall_cnt` SHALL increment on each load-use stall cycle.
REQ-030 `flush_cnt` SHALL increment on each ex_redirect cycle.
REQ-031 Both counters SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-032 While rst = 1 at an edge, all slots SHALL be set invalid, fwd selects SHALL be 00, and both counters SHALL be 0.
REQ-033 While rst = 1, stall_pc, stall_ifid, flush_ifid and flush_idex SHALL all be 0.
REQ-034 A reset asserted mid-stall or mid-redirect SHALL abort that action; the first cycle after reset deassertion SHALL show no hazard.

Verification
REQ-035 Scenario back-to-back ALU: addi x5 then add x6,x5,x5 -> no stall; fwd_rs1_sel = fwd_rs2_sel = 01 in the add's EX cycle.
REQ-036 Scenario load-use: lw x7 then add x8,x7,x0 -> one cycle with stall_pc = stall_ifid = flush_idex = 1; then fwd_rs1_sel = 10 and fwd_rs2_sel = 00; stall_cnt = 1.
REQ-037 Scenario x0 writer: lw x0 then add x1,x0,x0 -> no stall; both selects 00.
REQ-038 Scenario double producer: addi x3, addi x3, add x4,x3,x3 -> selects 01 (nearest producer), not 10.
REQ-039 Scenario simultaneous events: a taken beq in EX with a load-use pair in ID -> flush_ifid = flush_idex = 1, stall_pc = 0; flush_cnt +1 and stall_cnt unchanged.
REQ-040 Scenario reset mid-operation: rst asserted during a load-use stall -> all outputs 0 the next cycle; both counters 0.
